// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage: data RAM access, branch resolve, MEM/WB register
// Optional misalignment trap: define MEM_STAGE_MISALIGN_TRAP_EN.
module mem_wb_stage #(
    parameter  int MEM_DEPTH = 512,
    localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        RegWriteEN_In,
    input  logic [1:0]  Mem2RegSEL_In,
    input  logic        MemWriteEN_In,
    input  logic        Beq_In,
    input  logic        Bne_In,
    input  logic        ZeroFlag_In,
    input  logic [31:0] ALUResult_In,
    input  logic [31:0] WriteData_In,
    input  logic [4:0]  RegWBAddr_In,
    input  logic [31:0] PCPlus4_In,
    output logic        BranchTaken_Out,
    output logic        RegWriteEN_WB,
    output logic [4:0]  RegWBAddr_WB,
    output logic [31:0] WBData_WB,
    output logic        MisalignErr_Out
);

    logic [31:0]       mem [MEM_DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       rd_data;
    logic [31:0]       wb_mux;
    logic              is_load;
    logic              store_en;
    logic              load_fault;
    logic              unused_addr;

    assign word_idx    = ALUResult_In[ADDR_W+1:2];
    assign rd_data     = mem[word_idx];
    assign is_load     = (Mem2RegSEL_In == 2'b01);
    assign unused_addr = ^{ALUResult_In[31:ADDR_W+2], ALUResult_In[1:0]};

    assign BranchTaken_Out = (Beq_In & ZeroFlag_In) | (Bne_In & ~ZeroFlag_In);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic misalign;

    assign misalign   = (|ALUResult_In[1:0]) & (MemWriteEN_In | is_load);
    assign store_en   = MemWriteEN_In & ~misalign;
    assign load_fault = is_load & misalign;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            MisalignErr_Out <= 1'b0;
        end else if (misalign) begin
            MisalignErr_Out <= 1'b1;
        end
    end
`else
    assign store_en        = MemWriteEN_In;
    assign load_fault      = 1'b0;
    assign MisalignErr_Out = 1'b0;
`endif

    // RAM is never reset; gating on RESET_N drops a store caught by reset.
    always_ff @(posedge CLOCK) begin
        if (RESET_N && store_en) begin
            mem[word_idx] <= WriteData_In;
        end
    end

    always_comb begin
        wb_mux = ALUResult_In;
        case (Mem2RegSEL_In)
            2'b01:   wb_mux = rd_data;
            2'b10:   wb_mux = PCPlus4_In;
            default: wb_mux = ALUResult_In;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            RegWriteEN_WB <= 1'b0;
            RegWBAddr_WB  <= 5'd0;
            WBData_WB     <= 32'd0;
        end else begin
            RegWriteEN_WB <= RegWriteEN_In & ~load_fault;
            RegWBAddr_WB  <= RegWBAddr_In;
            WBData_WB     <= load_fault ? 32'd0 : wb_mux;
        end
    end

endmodule
